// File: rtl/tdm_slot_scheduler.sv
// tdm_slot_scheduler
//   Time-division front end that shares one fixed-function unit between two
//   security domains. Domain 0 (L) owns even slots and domain 1 (H) owns odd
//   slots. Each slot is SLOT_LEN cycles long. A domain may issue one request,
//   and only at the issue cycle of its own slot. The result is held and
//   released at the last cycle of that slot. Response timing therefore depends
//   only on the schedule, never on the other domain or on the unit's latency.
//
//   Optional build macro TDM_SCRUB_EN adds a guard cycle. Issue moves to
//   cnt==1, capture is limited to cnt 2..SLOT_LEN-2, and SLOT_LEN must be >= 4.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req0_* / req1_*            per-domain request (valid/data in, ready out)
//   rsp0_* / rsp1_*            per-domain response strobe + payload
//   res_valid/res_data         issue to the shared unit
//   res_dom                    current slot owner
//   res_rsp_valid/res_rsp_data result from the shared unit
//   overrun                    sticky: a result missed its slot deadline
module tdm_slot_scheduler #(
  parameter int W        = 16,
  parameter int SLOT_LEN = 8,
  parameter int CW       = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_data,
  output logic         req0_ready,
  output logic         rsp0_valid,
  output logic [W-1:0] rsp0_data,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_data,
  output logic         req1_ready,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp1_data,
  output logic         res_valid,
  output logic [W-1:0] res_data,
  output logic         res_dom,
  input  logic         res_rsp_valid,
  input  logic [W-1:0] res_rsp_data,
  output logic         overrun
);

`ifdef TDM_SCRUB_EN
  localparam int ISSUE_AT = 1;
  localparam int MIN_LEN  = 4;
`else
  localparam int ISSUE_AT = 0;
  localparam int MIN_LEN  = 3;
`endif

  localparam logic [CW-1:0] C_ISSUE = CW'(ISSUE_AT);
  localparam logic [CW-1:0] C_CAPHI = CW'(SLOT_LEN - 2);
  localparam logic [CW-1:0] C_LAST  = CW'(SLOT_LEN - 1);

  generate
    if (SLOT_LEN < MIN_LEN || SLOT_LEN > 256 || (2 ** CW) < SLOT_LEN) begin : g_bad_cfg
      $error("tdm_slot_scheduler: illegal SLOT_LEN/CW combination");
    end
  endgenerate

  logic [CW-1:0] r_cnt;
  logic          r_owner;
  logic          r_pending;
  logic          r_done;
  logic [W-1:0]  r_rbuf;
  logic          r_overrun;

  logic w_issue_slot, w_last, w_cap_win;
  logic w_issue0, w_issue1, w_issue, w_cap, w_rel;

  assign w_issue_slot = (r_cnt == C_ISSUE);
  assign w_last       = (r_cnt == C_LAST);
`ifdef TDM_SCRUB_EN
  assign w_cap_win    = (r_cnt >= CW'(2)) && (r_cnt <= C_CAPHI);
`else
  assign w_cap_win    = (r_cnt <= C_CAPHI);
`endif

  // Ready depends only on the schedule. It is masked while reset is held so
  // that a valid held through reset cannot issue to the unit.
  assign req0_ready = ~reset & w_issue_slot & ~r_owner;
  assign req1_ready = ~reset & w_issue_slot &  r_owner;

  assign w_issue0 = req0_valid & req0_ready;
  assign w_issue1 = req1_valid & req1_ready;
  assign w_issue  = w_issue0 | w_issue1;

  assign res_valid = w_issue;
  assign res_data  = w_issue0 ? req0_data : (w_issue1 ? req1_data : '0);
  assign res_dom   = r_owner;

  // A result is accepted only while a request is outstanding and the slot has
  // room left to release it. Stale or late results fall through.
  assign w_cap = res_rsp_valid & r_pending & w_cap_win;

  assign w_rel      = w_last & r_done;
  assign rsp0_valid = w_rel & ~r_owner;
  assign rsp1_valid = w_rel &  r_owner;
  assign rsp0_data  = rsp0_valid ? r_rbuf : '0;
  assign rsp1_data  = rsp1_valid ? r_rbuf : '0;

  assign overrun = r_overrun;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_owner   <= 1'b0;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
      r_rbuf    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_issue) begin
        r_pending <= 1'b1;
      end else if (w_cap) begin
        r_pending <= 1'b0;
        r_done    <= 1'b1;
        r_rbuf    <= res_rsp_data;
      end else if (w_last && r_pending) begin
        // Deadline missed: nothing is released and the slot closes clean.
        r_pending <= 1'b0;
        r_overrun <= 1'b1;
      end
      // Slot end: nothing survives into the next owner's slot. Capture never
      // fires in the last cycle, so this does not race the buffer write.
      if (w_last) begin
        r_cnt   <= '0;
        r_owner <= ~r_owner;
        r_done  <= 1'b0;
        r_rbuf  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
